// File: rtl/nexi_uart_tx.sv
// UART transmitter on the 16x bit-rate clock: start, 8 data bits LSB first,
// optional parity, 1 or 2 stop bits, with a one-byte holding register.
module nexi_uart_tx #(
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk_16x_bps,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       write_stb,
  output logic       ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_pin
);

  localparam logic       PAR_EN    = (PARITY == 1) || (PARITY == 2);
  localparam logic       PAR_ODD   = (PARITY == 1);
  localparam logic [2:0] LAST_STOP = (STOP_BITS == 2) ? 3'd1 : 3'd0;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  typedef struct packed {
    logic [7:0] shift;
    logic       par;
    logic [3:0] tick;
    logic [2:0] bcnt;
  } shf_t;

  state_t     state, state_nxt;
  shf_t       sh, sh_nxt;
  logic [7:0] hold, hold_nxt;
  logic       hold_full, hold_full_nxt;
  logic       tx_nxt;
  logic       bit_end;
  logic       load;

  assign bit_end = (sh.tick == 4'd15);
  assign ready   = ~hold_full;
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_nxt     = state;
    sh_nxt        = sh;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    tx_nxt        = tx_pin;
    load          = 1'b0;
    tx_done       = 1'b0;

    if (state != S_IDLE) sh_nxt.tick = sh.tick + 4'd1;

    // tx_nxt is the level of the *next* bit, so tx_pin only moves at bit boundaries
    case (state)
      S_IDLE: if (hold_full) load = 1'b1;
      S_START: if (bit_end) begin
        state_nxt   = S_DATA;
        sh_nxt.bcnt = 3'd0;
        tx_nxt      = sh.shift[0];
      end
      S_DATA: if (bit_end) begin
        sh_nxt.shift = {1'b0, sh.shift[7:1]};
        if (sh.bcnt == 3'd7) begin
          sh_nxt.bcnt = 3'd0;
          if (PAR_EN) begin
            state_nxt = S_PARITY;
            tx_nxt    = sh.par;
          end else begin
            state_nxt = S_STOP;
            tx_nxt    = 1'b1;
          end
        end else begin
          sh_nxt.bcnt = sh.bcnt + 3'd1;
          tx_nxt      = sh.shift[1];
        end
      end
      S_PARITY: if (bit_end) begin
        state_nxt   = S_STOP;
        sh_nxt.bcnt = 3'd0;
        tx_nxt      = 1'b1;
      end
      S_STOP: if (bit_end) begin
        if (sh.bcnt == LAST_STOP) begin
          tx_done = 1'b1;
          if (hold_full) load = 1'b1;
          else begin
            state_nxt = S_IDLE;
            tx_nxt    = 1'b1;
          end
        end else begin
          sh_nxt.bcnt = sh.bcnt + 3'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        tx_nxt    = 1'b1;
      end
    endcase

    // load needs hold_full, accept needs ~hold_full: never both in one cycle
    if (load) begin
      state_nxt     = S_START;
      sh_nxt.shift  = hold;
      sh_nxt.par    = PAR_ODD ? ~^hold : ^hold;
      sh_nxt.tick   = 4'd0;
      sh_nxt.bcnt   = 3'd0;
      hold_full_nxt = 1'b0;
      tx_nxt        = 1'b0;
    end

    if (write_stb && !hold_full) begin
      hold_nxt      = data_in;
      hold_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_16x_bps) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sh        <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      tx_pin    <= 1'b1;
    end else begin
      state     <= state_nxt;
      sh        <= sh_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
      tx_pin    <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_nexi_uart_tx.sv
// Bench for nexi_uart_tx: three parity/stop configurations, each with a
// scoreboard queue of written bytes and a line monitor acting as receiver.
module tb_nexi_uart_tx;

  logic   clk;
  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int P     = (g == 1) ? 2 : (g == 2) ? 1 : 0;
    localparam int S     = (g == 1) ? 2 : 1;
    localparam int NB    = 10 + ((P == 1 || P == 2) ? 1 : 0) + ((S == 2) ? 1 : 0);
    localparam int FLEN  = 16 * NB;
    localparam int NRAND = (g == 0) ? 256 : 40;

    logic       rst_n = 1'b0;
    logic       write_stb = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ready, busy, tx_done, tx_pin;
    logic       rst_seen;
    logic       fin = 1'b0;
    logic [7:0] exp_q[$];
    longint     starts_q[$];

    nexi_uart_tx #(.PARITY(P), .STOP_BITS(S)) dut (
      .clk_16x_bps(clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .write_stb  (write_stb),
      .ready      (ready),
      .busy       (busy),
      .tx_done    (tx_done),
      .tx_pin     (tx_pin)
    );

    // high when the last rising edge was a reset edge
    always @(posedge clk) rst_seen <= !rst_n;

    // line level of each bit slot of a frame carrying byte b
    function automatic logic [11:0] frame_bits(input logic [7:0] b);
      logic [11:0] f;
      int ones;
      f    = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = b[i];
      ones = $countones(b);
      if (P == 2) f[9] = (ones % 2 == 1);
      if (P == 1) f[9] = (ones % 2 == 0);
      return f;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL %s [inst %0d] got %0h want %0h", nm, g, act, exp);
      end
    endtask

    task automatic reset_check();
      chk("reset pin/busy/ready/done", 32'({tx_pin, busy, ready, tx_done}), 32'b1010);
      exp_q.delete();
    endtask

    initial begin : mon
      logic [11:0] fb;
      logic [7:0]  exp_b, got;
      int          lerr, cerr;
      bit          abort;
      forever begin
        @(negedge clk);
        if (rst_seen) reset_check();
        else if (tx_pin === 1'b0) begin
          starts_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected frame [inst %0d] got a start bit, want idle line", g);
            exp_b = 8'h00;
          end else exp_b = exp_q.pop_front();
          fb = frame_bits(exp_b);
          got = 8'h00; lerr = 0; cerr = 0; abort = 1'b0;
          for (int k = 0; k < FLEN; k++) begin
            if (k > 0) @(negedge clk);
            if (rst_seen) begin
              abort = 1'b1;
              break;
            end
            if (tx_pin !== fb[k/16]) lerr++;
            if (k % 16 == 8 && k / 16 >= 1 && k / 16 <= 8) got[k/16-1] = tx_pin;
            if (busy !== 1'b1 || tx_done !== (k == FLEN - 1)) cerr++;
          end
          chk("frame busy/tx_done errors", 32'(cerr), 32'd0);
          if (abort) reset_check();
          else begin
            chk("frame byte", 32'(got), 32'(exp_b));
            chk("frame bit-cycle errors", 32'(lerr), 32'd0);
          end
        end else chk("idle busy/tx_done", 32'({busy, tx_done}), 32'd0);
      end
    end

    task automatic send(input logic [7:0] b);
      int t = 0;
      while (ready !== 1'b1 && t < 4 * FLEN) begin
        @(negedge clk);
        t++;
      end
      if (ready !== 1'b1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ready timeout [inst %0d] ready=%b want 1", g, ready);
        return;
      end
      data_in   = b;
      write_stb = 1'b1;
      @(posedge clk);
      exp_q.push_back(b);
      @(negedge clk);
      write_stb = 1'b0;
    endtask

    task automatic wait_idle();
      int t = 0;
      while (!(busy === 1'b0 && ready === 1'b1) && t < 4 * FLEN) begin
        @(negedge clk);
        t++;
      end
      if (!(busy === 1'b0 && ready === 1'b1)) begin
        n_cmp++;
        n_bad++;
        $display("FAIL idle timeout [inst %0d] busy=%b ready=%b want 0/1", g, busy, ready);
      end
    endtask

    task automatic wait_done();
      int t = 0;
      while (tx_done !== 1'b1 && t < 4 * FLEN) begin
        @(negedge clk);
        t++;
      end
      if (tx_done !== 1'b1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL tx_done timeout [inst %0d] tx_done=%b want 1", g, tx_done);
      end
    endtask

    task automatic gap_check(input string nm, input int want);
      if (starts_q.size() < 2) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s [inst %0d] got %0d frames want 2", nm, g, starts_q.size());
      end else chk(nm, 32'(starts_q[$] - starts_q[$-1]), 32'(want));
    endtask

    initial begin : stim
      int bad;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post-reset ready/busy/pin", 32'({ready, busy, tx_pin}), 32'b101);

      // single byte, load latency
      send(8'h55);
      chk("accepted, still idle", 32'({ready, tx_pin, busy}), 32'b010);
      @(negedge clk);
      chk("start bit one edge later", 32'({ready, tx_pin, busy}), 32'b101);
      wait_idle();

      // back-to-back through the holding register
      starts_q.delete();
      send(8'hA5);
      send(8'h3C);
      wait_idle();
      gap_check("back-to-back spacing", FLEN);

      // write while full is dropped
      send(8'h11);
      send(8'h22);
      data_in   = 8'h33;
      write_stb = 1'b1;
      repeat (20) @(negedge clk);
      chk("ready low while hold full", 32'(ready), 32'd0);
      write_stb = 1'b0;
      wait_done();
      chk("hold full on final stop", 32'(ready), 32'd0);
      @(negedge clk);
      chk("reload frees hold, start bit", 32'({ready, tx_pin}), 32'b10);
      wait_idle();
      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

      // parity byte
      send(8'h07);
      wait_idle();

      // reset in data bit 3, queued byte discarded
      send(8'hF0);
      send(8'h99);
      repeat (70) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort ready/busy/pin", 32'({ready, busy, tx_pin}), 32'b101);
      send(8'h0F);
      wait_idle();

      // write on the final stop cycle: one idle cycle before the next frame
      starts_q.delete();
      send(8'h5A);
      wait_done();
      data_in   = 8'hC3;
      write_stb = 1'b1;
      @(posedge clk);
      exp_q.push_back(8'hC3);
      @(negedge clk);
      write_stb = 1'b0;
      chk("final-stop write held", 32'({tx_pin, busy, ready}), 32'b100);
      wait_idle();
      gap_check("final-stop write spacing", FLEN + 1);

      // random stream
      starts_q.delete();
      repeat (NRAND) send(8'($urandom_range(0, 255)));
      wait_idle();
      bad = 0;
      for (int i = 1; i < starts_q.size(); i++)
        if (starts_q[i] - starts_q[i-1] != FLEN) bad++;
      chk("stream gaps", 32'(bad), 32'd0);
      chk("stream frame count", 32'(starts_q.size()), 32'(NRAND));
      chk("stream scoreboard drained", 32'(exp_q.size()), 32'd0);
      fin = 1'b1;
    end
  end

  initial begin : watchdog
    int t = 0;
    while (!(inst[0].fin && inst[1].fin && inst[2].fin) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog got %0d cycles want completion", t);
    end
    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
